// File: rtl/path_sequencer.sv
// Latches a packed path, drops leading padding and the occupied node, then issues targets one per handshake.
// Latency: first target N+1 cycles after path_valid (N = groups skipped); target_valid holds until target_ready.
module path_sequencer #(
  parameter int NODE_W = 5,
  parameter int NODES  = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NODE_W*NODES-1:0]  path_in,
  input  logic                     path_valid,
  input  logic                     target_ready,
  output logic [NODE_W-1:0]        target_node,
  output logic                     target_valid,
  output logic [NODE_W-1:0]        cur_node,
  output logic                     busy,
  output logic                     new_path,
  output logic                     path_drop
);

  localparam int PW = NODE_W * NODES;
  localparam int IW = $clog2(NODES);
  localparam logic [IW-1:0] LAST = IW'(NODES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    sreg;
  logic [IW-1:0]    idx;
  logic             skipped_cur;

  logic [NODE_W-1:0] head;
  logic [NODE_W-1:0] next_head;
  logic              skip_pad;
  logic              skip_cur;

  assign head      = sreg[PW-1 -: NODE_W];
  assign next_head = sreg[PW-NODE_W-1 -: NODE_W];

  // skipped_cur doubles as "a nonzero group has been seen": once set, zeros are real targets
  assign skip_pad = (head == '0) && !skipped_cur;
  assign skip_cur = (head != '0) && !skipped_cur && (head == cur_node);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sreg         <= '0;
      idx          <= '0;
      skipped_cur  <= 1'b0;
      target_node  <= '0;
      target_valid <= 1'b0;
      cur_node     <= '0;
      busy         <= 1'b0;
      new_path     <= 1'b0;
      path_drop    <= 1'b0;
    end else begin
      new_path  <= 1'b0;
      path_drop <= path_valid && (state != IDLE);
      case (state)
        IDLE: begin
          if (path_valid) begin
            sreg        <= path_in;
            idx         <= '0;
            skipped_cur <= 1'b0;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (skip_pad || skip_cur) begin
            if (skip_cur) skipped_cur <= 1'b1;
            sreg <= sreg << NODE_W;
            idx  <= idx + 1'b1;
            if (idx == LAST) begin
              new_path <= 1'b1;
              state    <= DONE;
            end
          end else begin
            target_node  <= head;
            target_valid <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (target_ready) begin
            cur_node <= target_node;
            if (idx == LAST) begin
              target_valid <= 1'b0;
              new_path     <= 1'b1;
              state        <= DONE;
            end else begin
              sreg        <= sreg << NODE_W;
              idx         <= idx + 1'b1;
              target_node <= next_head;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
